hough_accumulator: RTL and testbench

Vote-accumulation stage directly downstream of `hough_transformer`. It consumes one (r, angle) vote per cycle, increments the matching bin of an (angle × r) vote array with a read-modify-write pipeline, and sweeps the array for the strongest line on request. It also clears the array between frames and feeds the line-extraction logic with the winning bin.

---
 rtl/hough_pkg.sv | 21 ++
 rtl/hough_accumulator_vote_ram.sv | 32 +++
 rtl/hough_accumulator.sv | 249 ++++++++++++++++++++++++
 tb/tb_hough_accumulator.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/hough_pkg.sv
// Shared constants and state encoding for the Hough transform / accumulator pair.
package hough_pkg;

  localparam int HOUGH_R_W         = 13;
  localparam int HOUGH_R_OFFSET    = 512;
  localparam int HOUGH_R_SHIFT     = 2;
  localparam int HOUGH_R_BINS      = 512;
  localparam int HOUGH_A_BINS      = 45;
  localparam int HOUGH_CNT_W       = 16;
  localparam int HOUGH_ANGLE_STEP  = 4;
  localparam int HOUGH_ANGLE_SHIFT = $clog2(HOUGH_ANGLE_STEP);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_ACCUM,
    ST_SCAN_FLUSH,
    ST_SCAN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/hough_accumulator_vote_ram.sv
// Simple dual-port vote array: one write port, one synchronous read port.
// The read returns the old contents when it hits the address being written
// in the same cycle; the accumulator bypasses that case itself.
module vote_ram #(
  parameter int DEPTH  = 23040,
  parameter int WIDTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Write and registered read; the array itself is never reset.
  // NOTE: block RAM has no reset path, so the contents are zeroed by the
  // accumulator's CLEAR sweep instead of by rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/hough_accumulator.sv
// Vote accumulator: read-modify-write of (angle x r) bins, array clear and
// peak search over the whole array.
module hough_accumulator
  import hough_pkg::*;
#(
  parameter int R_W      = HOUGH_R_W,
  parameter int R_OFFSET = HOUGH_R_OFFSET,
  parameter int R_SHIFT  = HOUGH_R_SHIFT,
  parameter int R_BINS   = HOUGH_R_BINS,
  parameter int A_BINS   = HOUGH_A_BINS,
  parameter int CNT_W    = HOUGH_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      vote_valid,
  input  logic [R_W-1:0]            vote_r,
  input  logic [7:0]                vote_angle,
  output logic                      vote_ready,
  input  logic                      clear_start,
  input  logic                      scan_start,
  output logic                      busy,
  output logic                      peak_valid,
  output logic [CNT_W-1:0]          peak_count,
  output logic [$clog2(R_BINS)-1:0] peak_r_bin,
  output logic [5:0]                peak_angle_idx,
  output logic [15:0]               drop_count
);

  localparam int DEPTH  = A_BINS * R_BINS;
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int RB_W   = $clog2(R_BINS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   SCAN_END  = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic              to_clear_q, to_clear_d;
  logic              s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
  logic              s2_valid_q, s2_valid_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic [CNT_W-1:0]  s2_data_q, s2_data_d;
  logic              w_valid_q, w_valid_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [CNT_W-1:0]  w_data_q, w_data_d;
  logic [ADDR_W:0]   scan_addr_q, scan_addr_d;
  logic              cmp_valid_q, cmp_valid_d;
  logic [ADDR_W-1:0] cmp_addr_q, cmp_addr_d;
  logic [CNT_W-1:0]  best_count_q, best_count_d;
  logic [ADDR_W-1:0] best_addr_q, best_addr_d;
  logic [CNT_W-1:0]  peak_count_q, peak_count_d;
  logic [ADDR_W-1:0] peak_addr_q, peak_addr_d;

  int                r_sum, r_bin, a_idx;
  logic              vote_in_range, vote_accept;
  logic [ADDR_W-1:0] vote_addr;
  logic [CNT_W-1:0]  s1_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
  logic [CNT_W-1:0]  ram_wr_data, ram_rd_data;

  // Map an incoming vote to a bin address and flag out-of-range votes.
  always_comb begin
    r_sum         = int'($signed(vote_r)) + R_OFFSET;
    r_bin         = r_sum >>> R_SHIFT;
    a_idx         = int'(vote_angle) >> HOUGH_ANGLE_SHIFT;
    vote_in_range = (r_sum >= 0) && (r_bin < R_BINS) && (a_idx < A_BINS);
    vote_addr     = ADDR_W'(a_idx * R_BINS + r_bin);
  end

  assign vote_ready  = (state_q == ST_ACCUM);
  assign vote_accept = vote_valid && vote_ready;

  // Increment pipeline: stage 1 picks the freshest copy of its bin, stage 2 writes it back.
  always_comb begin
    s1_valid_d = vote_accept && vote_in_range;
    s1_addr_d  = vote_addr;
    // The write that landed on the cycle the read was issued is not in q yet.
    s1_data = ram_rd_data;
    if (w_valid_q && (w_addr_q == s1_addr_q)) begin
      s1_data = w_data_q;
    end
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      s1_data = s2_data_q;
    end
    s2_valid_d = s1_valid_q;
    s2_addr_d  = s1_addr_q;
    s2_data_d  = (s1_data == '1) ? s1_data : s1_data + CNT_W'(1);
    w_valid_d  = s2_valid_q;
    w_addr_d   = s2_addr_q;
    w_data_d   = s2_data_q;
  end

  // Control FSM: clear sweep, vote accounting, drain, peak search.
  // NOTE: every output of this block is defaulted first so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    drop_count_d = drop_count_q;
    to_clear_d   = to_clear_q;
    scan_addr_d  = scan_addr_q;
    cmp_valid_d  = 1'b0;
    cmp_addr_d   = cmp_addr_q;
    best_count_d = best_count_q;
    best_addr_d  = best_addr_q;
    peak_count_d = peak_count_q;
    peak_addr_d  = peak_addr_q;
    case (state_q)
      ST_CLEAR: begin
        drop_count_d = '0;
        clr_addr_d   = clr_addr_q + ADDR_W'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (vote_accept && !vote_in_range && (drop_count_q != 16'hFFFF)) begin
          drop_count_d = drop_count_q + 16'd1;
        end
        // Both requests drain the pipeline first; clear takes priority.
        if (clear_start) begin
          state_d    = ST_SCAN_FLUSH;
          to_clear_d = 1'b1;
        end else if (scan_start) begin
          state_d    = ST_SCAN_FLUSH;
          to_clear_d = 1'b0;
        end
      end
      ST_SCAN_FLUSH: begin
        if (!s1_valid_q && !s2_valid_q) begin
          if (to_clear_q) begin
            state_d    = ST_CLEAR;
            clr_addr_d = '0;
          end else begin
            state_d      = ST_SCAN;
            scan_addr_d  = '0;
            best_count_d = '0;
            best_addr_d  = '0;
          end
        end
      end
      ST_SCAN: begin
        if (scan_addr_q < SCAN_END) begin
          scan_addr_d = scan_addr_q + (ADDR_W + 1)'(1);
          cmp_valid_d = 1'b1;
          cmp_addr_d  = scan_addr_q[ADDR_W-1:0];
        end
        // Strict compare keeps the lowest address on ties.
        if (cmp_valid_q && (ram_rd_data > best_count_q)) begin
          best_count_d = ram_rd_data;
          best_addr_d  = cmp_addr_q;
        end
        if (cmp_valid_q && (cmp_addr_q == LAST_ADDR)) begin
          state_d      = ST_DONE;
          peak_count_d = best_count_d;
          peak_addr_d  = best_addr_d;
        end
      end
      ST_DONE: begin
        state_d = ST_ACCUM;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  // RAM port steering: the clear sweep owns the write port while in CLEAR.
  always_comb begin
    ram_we      = s2_valid_q;
    ram_wr_addr = s2_addr_q;
    ram_wr_data = s2_data_q;
    if (state_q == ST_CLEAR) begin
      ram_we      = 1'b1;
      ram_wr_addr = clr_addr_q;
      ram_wr_data = '0;
    end
    ram_rd_addr = (state_q == ST_SCAN) ? scan_addr_q[ADDR_W-1:0] : vote_addr;
  end

  // State and datapath registers; reset abandons any in-flight vote.
  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CLEAR;
      clr_addr_q   <= '0;
      drop_count_q <= '0;
      to_clear_q   <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_addr_q    <= '0;
      s2_valid_q   <= 1'b0;
      s2_addr_q    <= '0;
      s2_data_q    <= '0;
      w_valid_q    <= 1'b0;
      w_addr_q     <= '0;
      w_data_q     <= '0;
      scan_addr_q  <= '0;
      cmp_valid_q  <= 1'b0;
      cmp_addr_q   <= '0;
      best_count_q <= '0;
      best_addr_q  <= '0;
      peak_count_q <= '0;
      peak_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      drop_count_q <= drop_count_d;
      to_clear_q   <= to_clear_d;
      s1_valid_q   <= s1_valid_d;
      s1_addr_q    <= s1_addr_d;
      s2_valid_q   <= s2_valid_d;
      s2_addr_q    <= s2_addr_d;
      s2_data_q    <= s2_data_d;
      w_valid_q    <= w_valid_d;
      w_addr_q     <= w_addr_d;
      w_data_q     <= w_data_d;
      scan_addr_q  <= scan_addr_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_addr_q   <= cmp_addr_d;
      best_count_q <= best_count_d;
      best_addr_q  <= best_addr_d;
      peak_count_q <= peak_count_d;
      peak_addr_q  <= peak_addr_d;
    end
  end

  vote_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (CNT_W),
    .ADDR_W (ADDR_W)
  ) u_vote_ram (
    .clk     (clk),
    .we      (ram_we),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data),
    .rd_addr (ram_rd_addr),
    .rd_data (ram_rd_data)
  );

  assign busy = (state_q == ST_CLEAR) || (state_q == ST_SCAN_FLUSH) ||
                (state_q == ST_SCAN) || s1_valid_q || s2_valid_q;
  assign peak_valid     = (state_q == ST_DONE);
  assign peak_count     = peak_count_q;
  assign peak_r_bin     = peak_addr_q[RB_W-1:0];
  assign peak_angle_idx = 6'(peak_addr_q >> RB_W);
  assign drop_count     = drop_count_q;

endmodule

// File: tb/tb_hough_accumulator.sv
// Directed bench for hough_accumulator with a reduced array (4 angles x 512
// r bins, 8-bit counters) so clear, scan and saturation fit a short run.
module tb_hough_accumulator;

  localparam int R_W    = 13;
  localparam int A_BINS = 4;
  localparam int R_BINS = 512;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = A_BINS * R_BINS;
  localparam int RB_W   = $clog2(R_BINS);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vote_valid = 1'b0;
  logic [R_W-1:0]   vote_r = '0;
  logic [7:0]       vote_angle = '0;
  logic             clear_start = 1'b0;
  logic             scan_start = 1'b0;
  logic             vote_ready;
  logic             busy;
  logic             peak_valid;
  logic [CNT_W-1:0] peak_count;
  logic [RB_W-1:0]  peak_r_bin;
  logic [5:0]       peak_angle_idx;
  logic [15:0]      drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  hough_accumulator #(
    .R_W      (R_W),
    .R_OFFSET (512),
    .R_SHIFT  (2),
    .R_BINS   (R_BINS),
    .A_BINS   (A_BINS),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vote_valid     (vote_valid),
    .vote_r         (vote_r),
    .vote_angle     (vote_angle),
    .vote_ready     (vote_ready),
    .clear_start    (clear_start),
    .scan_start     (scan_start),
    .busy           (busy),
    .peak_valid     (peak_valid),
    .peak_count     (peak_count),
    .peak_r_bin     (peak_r_bin),
    .peak_angle_idx (peak_angle_idx),
    .drop_count     (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Present one vote for one cycle; consecutive calls are back to back.
  task automatic drive_vote(input int r, input int angle);
    @(negedge clk);
    vote_valid = 1'b1;
    vote_r     = R_W'(r);
    vote_angle = 8'(angle);
  endtask

  task automatic end_votes();
    @(negedge clk);
    vote_valid = 1'b0;
  endtask

  task automatic run_scan(input string tag, input int exp_cnt, input int exp_rbin, input int exp_aidx);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    for (int i = 0; i < DEPTH + 100 && !seen; i++) begin
      if (peak_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, " peak_valid seen"}, 32'(seen), 32'd1);
    check({tag, " peak_count"}, 32'(peak_count), 32'(exp_cnt));
    check({tag, " peak_r_bin"}, 32'(peak_r_bin), 32'(exp_rbin));
    check({tag, " peak_angle_idx"}, 32'(peak_angle_idx), 32'(exp_aidx));
    @(negedge clk);
    check({tag, " peak_valid one cycle"}, 32'(peak_valid), 32'd0);
  endtask

  initial begin
    bit ready_seen;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst vote_ready", 32'(vote_ready), 32'd0);
    check("rst busy", 32'(busy), 32'd1);
    check("rst peak_valid", 32'(peak_valid), 32'd0);
    check("rst peak_count", 32'(peak_count), 32'd0);
    check("rst peak_r_bin", 32'(peak_r_bin), 32'd0);
    check("rst peak_angle_idx", 32'(peak_angle_idx), 32'd0);
    check("rst drop_count", 32'(drop_count), 32'd0);

    // Initial clear takes exactly DEPTH cycles
    rst_n = 1'b1;
    repeat (DEPTH - 1) @(posedge clk);
    #1;
    check("clear last cycle busy", 32'(busy), 32'd1);
    check("clear last cycle vote_ready", 32'(vote_ready), 32'd0);
    @(posedge clk);
    #1;
    check("after clear vote_ready", 32'(vote_ready), 32'd1);
    check("after clear busy", 32'(busy), 32'd0);

    run_scan("empty", 0, 0, 0);

    // Back-to-back identical votes: r=100 -> bin 153, angle 8 -> idx 2
    for (int i = 0; i < 5; i++) drive_vote(100, 8);
    end_votes();
    run_scan("repeat", 5, 153, 2);

    // Interleaved bins (A,B,A,...) plus a smaller third bin; tie goes to addr 128
    for (int i = 0; i < 10; i++) begin
      drive_vote(0, 0);
      drive_vote(0, 4);
    end
    for (int i = 0; i < 3; i++) drive_vote(40, 4);
    end_votes();
    run_scan("tie", 10, 128, 0);

    // Out-of-range votes plus the two in-range r extremes
    drive_vote(-600, 0);
    drive_vote(1600, 0);
    drive_vote(0, 180);
    drive_vote(-512, 0);
    drive_vote(1535, 0);
    end_votes();
    @(negedge clk);
    check("drop_count", 32'(drop_count), 32'd3);
    run_scan("drops", 10, 128, 0);

    // Saturation of an 8-bit counter in the last angle bin
    for (int i = 0; i < 260; i++) drive_vote(0, 12);
    end_votes();
    run_scan("saturate", 255, 128, 3);

    // Clear and scan requested together: clear must win
    @(negedge clk);
    clear_start = 1'b1;
    scan_start  = 1'b1;
    @(negedge clk);
    clear_start = 1'b0;
    scan_start  = 1'b0;
    check("clear req busy", 32'(busy), 32'd1);
    check("clear req vote_ready", 32'(vote_ready), 32'd0);
    ready_seen = 1'b0;
    for (int i = 0; i < DEPTH + 50 && !ready_seen; i++) begin
      if (vote_ready) ready_seen = 1'b1;
      else @(negedge clk);
    end
    check("clear done vote_ready", 32'(ready_seen), 32'd1);
    check("clear drop_count", 32'(drop_count), 32'd0);
    run_scan("cleared", 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
